multicycle_controller: RTL

Moore-style control FSM for the multicycle MIPS datapath. It sits opposite the ALU on the control/status interface: it drives `alucontrol` and the datapath enables, and consumes the ALU `zero` flag. Each instruction executes over 3–5 cycles. Opcode and funct come from the datapath's instruction register.

---
 rtl/multicycle_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath.
// The states are Moore states: every output except pcen depends only on the
// current state and funct. pcen also uses the ALU zero flag so that a taken
// beq can load the PC.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_functalu;
  logic       w_functok;
  logic       w_pcwrite;
  logic       w_branch;

  // R-type funct decode: ALU operation and whether the funct is supported
  always_comb begin
    w_functalu = ALU_ADD;
    w_functok  = 1'b1;
    case (funct)
      6'b100000: w_functalu = ALU_ADD;
      6'b100010: w_functalu = ALU_SUB;
      6'b100100: w_functalu = ALU_AND;
      6'b100101: w_functalu = ALU_OR;
      6'b101010: w_functalu = ALU_SLT;
      default:   w_functok  = 1'b0;
    endcase
  end

  // State register, asynchronously forced to FETCH by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; unknown opcodes and functs fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_functok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = S_MEMWB;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEXEC: w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Per-state output decode; everything defaults to inactive with an ADD
  always_comb begin
    alucontrol = ALU_ADD;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:    iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = w_functalu;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        w_branch   = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:   regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = w_pcwrite | (w_branch & zero);
  assign state = r_state;

endmodule
